fetch_pc_unit: RTL and testbench

- Instruction-fetch stage directly downstream of the two-grant rotating warp arbiter.
- Holds one PC per warp and converts the arbiter's two one-hot raw grants (slot 0 and slot 1) into two I-cache read addresses per cycle.
- Advances granted PCs and applies task-manager start PCs and SIMT branch redirects.
- Registers warp ID, PC and valid alongside the synchronous I-cache read, then presents up to two fetched instructions per cycle to the decode stage.

---
 rtl/gpu_fetch_pkg.sv | 28 ++
 rtl/onehot_to_bin.sv | 20 ++
 rtl/fetch_pc_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_pc_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gpu_fetch_pkg.sv
// Shared widths, types and PC arithmetic for the instruction-fetch stage.
package gpu_fetch_pkg;

   localparam int unsigned NUM_WARPS  = 8;
   localparam int unsigned PC_WIDTH   = 32;
   localparam int unsigned INST_WIDTH = 32;
   localparam int unsigned PC_INCR    = 4;
   localparam int unsigned WARP_ID_W  = $clog2(NUM_WARPS);
   localparam int unsigned CNT_WIDTH  = 32;

   typedef logic [WARP_ID_W-1:0]  warp_id_t;
   typedef logic [PC_WIDTH-1:0]   pc_t;
   typedef logic [INST_WIDTH-1:0] inst_t;
   typedef logic [NUM_WARPS-1:0]  warp_mask_t;

   // One fetch slot as it travels alongside the I-cache read.
   typedef struct packed {
      logic     valid;
      warp_id_t wid;
      pc_t      pc;
   } fetch_slot_t;

   // Sequential PC advance; wraps silently at 2^PC_WIDTH.
   function automatic pc_t pc_next(input pc_t pc);
      return pc + PC_WIDTH'(PC_INCR);
   endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot (or zero) to binary encoder; a zero input encodes to 0.
module onehot_to_bin #(
   parameter int unsigned N = 8,
   parameter int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] onehot_i,
   output logic [W-1:0] bin_o
);

   // OR of the indices of set bits; exact for legal one-hot input.
   always_comb begin
      bin_o = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (onehot_i[i]) begin
            bin_o = bin_o | W'(i);
         end
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Per-warp PC file, dual-slot I-cache issue and stage-1 fetch register.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/squash counters.
module fetch_pc_unit
   import gpu_fetch_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  warp_mask_t GRT_raw_1_RR_IF,
   input  warp_mask_t GRT_raw_2_RR_IF,
   input  warp_mask_t UpdatePC_TM_PC,
   input  pc_t        StartPC_TM_PC,
   input  warp_mask_t Branch_SIMT_PC,
   input  pc_t        Target_SIMT_PC,
   output pc_t        Addr0_IF_IC,
   output pc_t        Addr1_IF_IC,
   output logic       Rd0_IF_IC,
   output logic       Rd1_IF_IC,
   input  inst_t      Inst0_IC_IF,
   input  inst_t      Inst1_IC_IF,
   output logic       Valid_IF_ID0,
   output logic       Valid_IF_ID1,
   output warp_id_t   WarpID_IF_ID0,
   output warp_id_t   WarpID_IF_ID1,
   output pc_t        PC_IF_ID0,
   output pc_t        PC_IF_ID1,
   output inst_t      Inst_IF_ID0,
   output inst_t      Inst_IF_ID1
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] FetchCnt_IF,
   output logic [CNT_WIDTH-1:0] SquashCnt_IF
`endif
);

   warp_id_t    enc0, enc1;
   warp_mask_t  redirect;
   pc_t         pc_q [NUM_WARPS];
   pc_t         pc_d [NUM_WARPS];
   fetch_slot_t issue0, issue1;
   fetch_slot_t s1_0_d, s1_1_d, s1_0_q, s1_1_q;

   onehot_to_bin #(.N(NUM_WARPS), .W(WARP_ID_W)) u_enc0 (
      .onehot_i (GRT_raw_1_RR_IF),
      .bin_o    (enc0)
   );

   onehot_to_bin #(.N(NUM_WARPS), .W(WARP_ID_W)) u_enc1 (
      .onehot_i (GRT_raw_2_RR_IF),
      .bin_o    (enc1)
   );

   // Any TM load or branch kills fetches of that warp, both issuing and in flight.
   assign redirect = UpdatePC_TM_PC | Branch_SIMT_PC;

   // Combinational issue toward the synchronous I-cache.
   always_comb begin
      issue0.valid = |GRT_raw_1_RR_IF;
      issue0.wid   = enc0;
      issue0.pc    = issue0.valid ? pc_q[enc0] : '0;
      issue1.valid = |GRT_raw_2_RR_IF;
      issue1.wid   = enc1;
      issue1.pc    = issue1.valid ? pc_q[enc1] : '0;
   end

   assign Rd0_IF_IC   = issue0.valid;
   assign Rd1_IF_IC   = issue1.valid;
   assign Addr0_IF_IC = issue0.pc;
   assign Addr1_IF_IC = issue1.pc;

   // Per-warp PC next state: TM load, then branch, then sequential advance.
   always_comb begin
      pc_d = pc_q;
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
         if (UpdatePC_TM_PC[w]) begin
            pc_d[w] = StartPC_TM_PC;
         end else if (Branch_SIMT_PC[w]) begin
            pc_d[w] = Target_SIMT_PC;
         end else if (GRT_raw_1_RR_IF[w] || GRT_raw_2_RR_IF[w]) begin
            pc_d[w] = pc_next(pc_q[w]);
         end
      end
   end

   // Same-cycle squash applied before the slot enters stage 1.
   always_comb begin
      s1_0_d       = issue0;
      s1_1_d       = issue1;
      s1_0_d.valid = issue0.valid & ~redirect[issue0.wid];
      s1_1_d.valid = issue1.valid & ~redirect[issue1.wid];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            pc_q[w] <= '0;
         end
         s1_0_q <= '0;
         s1_1_q <= '0;
      end else begin
         pc_q   <= pc_d;
         s1_0_q <= s1_0_d;
         s1_1_q <= s1_1_d;
      end
   end

   // In-flight squash for redirects arriving while the I-cache read completes.
   assign Valid_IF_ID0  = s1_0_q.valid & ~redirect[s1_0_q.wid];
   assign Valid_IF_ID1  = s1_1_q.valid & ~redirect[s1_1_q.wid];
   assign WarpID_IF_ID0 = s1_0_q.wid;
   assign WarpID_IF_ID1 = s1_1_q.wid;
   assign PC_IF_ID0     = s1_0_q.pc;
   assign PC_IF_ID1     = s1_1_q.pc;
   assign Inst_IF_ID0   = Inst0_IC_IF;
   assign Inst_IF_ID1   = Inst1_IC_IF;

`ifdef FETCH_PERF_CNT_EN
   logic [1:0]           fetch_inc, squash_inc;
   logic [CNT_WIDTH-1:0] fetch_cnt_q, fetch_cnt_d, squash_cnt_q, squash_cnt_d;

   function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [1:0]           b);
      logic [CNT_WIDTH:0] sum;
      sum = (CNT_WIDTH+1)'(a) + (CNT_WIDTH+1)'(b);
      return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
   endfunction

   always_comb begin
      fetch_inc    = 2'(Valid_IF_ID0) + 2'(Valid_IF_ID1);
      squash_inc   = 2'(s1_0_q.valid & redirect[s1_0_q.wid])
                   + 2'(s1_1_q.valid & redirect[s1_1_q.wid]);
      fetch_cnt_d  = sat_add(fetch_cnt_q, fetch_inc);
      squash_cnt_d = sat_add(squash_cnt_q, squash_inc);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q  <= '0;
         squash_cnt_q <= '0;
      end else begin
         fetch_cnt_q  <= fetch_cnt_d;
         squash_cnt_q <= squash_cnt_d;
      end
   end

   assign FetchCnt_IF  = fetch_cnt_q;
   assign SquashCnt_IF = squash_cnt_q;
`endif

   // Arbiter contract: grants one-hot or zero, slots never collide.
   a_grt1_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(GRT_raw_1_RR_IF));
   a_grt2_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(GRT_raw_2_RR_IF));
   a_grt_distinct : assert property (@(posedge clk) disable iff (!rst_n)
      !((GRT_raw_1_RR_IF != '0) && (GRT_raw_1_RR_IF == GRT_raw_2_RR_IF)));

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a per-warp PC / in-flight fetch model.
module tb_fetch_pc_unit;

   logic        clk;
   logic        rst_n;
   logic [7:0]  grt1, grt2, upd, br;
   logic [31:0] start_pc, target;
   logic [31:0] addr0, addr1, inst0, inst1, pco0, pco1, insto0, insto1;
   logic        rd0, rd1, v0, v1;
   logic [2:0]  wid0, wid1;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fcnt, scnt;
`endif

   int checks = 0;
   int fails  = 0;

   // Model state: architectural PCs and the fetch issued in the previous cycle.
   logic [31:0] m_pc [8];
   logic        m_pv0, m_pv1;
   int          m_pw0, m_pw1;
   logic [31:0] m_pp0, m_pp1;
   int          m_fetch, m_squash;

   fetch_pc_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .GRT_raw_1_RR_IF (grt1),
      .GRT_raw_2_RR_IF (grt2),
      .UpdatePC_TM_PC  (upd),
      .StartPC_TM_PC   (start_pc),
      .Branch_SIMT_PC  (br),
      .Target_SIMT_PC  (target),
      .Addr0_IF_IC     (addr0),
      .Addr1_IF_IC     (addr1),
      .Rd0_IF_IC       (rd0),
      .Rd1_IF_IC       (rd1),
      .Inst0_IC_IF     (inst0),
      .Inst1_IC_IF     (inst1),
      .Valid_IF_ID0    (v0),
      .Valid_IF_ID1    (v1),
      .WarpID_IF_ID0   (wid0),
      .WarpID_IF_ID1   (wid1),
      .PC_IF_ID0       (pco0),
      .PC_IF_ID1       (pco1),
      .Inst_IF_ID0     (insto0),
      .Inst_IF_ID1     (insto1)
`ifdef FETCH_PERF_CNT_EN
      ,
      .FetchCnt_IF     (fcnt),
      .SquashCnt_IF    (scnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic int enc(input logic [7:0] g);
      for (int i = 0; i < 8; i++) if (g[i]) return i;
      return 0;
   endfunction

   // Compare every DUT output against the model for the current cycle.
   task automatic compare();
      logic        e_v0, e_v1, kill;
      logic [7:0]  redir;
      redir = upd | br;
      chk("rd0", 32'(rd0), 32'(grt1 != 0));
      chk("rd1", 32'(rd1), 32'(grt2 != 0));
      chk("addr0", addr0, (grt1 != 0) ? m_pc[enc(grt1)] : 32'h0);
      chk("addr1", addr1, (grt2 != 0) ? m_pc[enc(grt2)] : 32'h0);
      e_v0 = m_pv0 && !redir[m_pw0];
      e_v1 = m_pv1 && !redir[m_pw1];
      chk("valid0", 32'(v0), 32'(e_v0));
      chk("valid1", 32'(v1), 32'(e_v1));
      if (m_pv0) begin
         chk("wid0", 32'(wid0), 32'(m_pw0));
         chk("pc0", pco0, m_pp0);
      end
      if (m_pv1) begin
         chk("wid1", 32'(wid1), 32'(m_pw1));
         chk("pc1", pco1, m_pp1);
      end
      chk("inst0", insto0, inst0);
      chk("inst1", insto1, inst1);
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_cnt", fcnt, 32'(m_fetch));
      chk("squash_cnt", scnt, 32'(m_squash));
`endif
      m_fetch  += int'(e_v0) + int'(e_v1);
      kill = m_pv0 && redir[m_pw0];
      m_squash += int'(kill);
      kill = m_pv1 && redir[m_pw1];
      m_squash += int'(kill);
   endtask

   // Drive one cycle's inputs away from the edge, then check.
   task automatic drive(input logic [7:0] g1, input logic [7:0] g2,
                        input logic [7:0] u, input logic [31:0] sp,
                        input logic [7:0] b, input logic [31:0] tg);
      @(negedge clk);
      grt1 = g1; grt2 = g2; upd = u; start_pc = sp; br = b; target = tg;
      inst0 = $urandom; inst1 = $urandom;
      #1 compare();
   endtask

   // Advance the clock and apply the architectural update rules to the model.
   task automatic tick();
      logic [7:0]  redir;
      logic [31:0] nxt [8];
      redir = upd | br;
      @(posedge clk);
      m_pv0 = (grt1 != 0) && !redir[enc(grt1)];
      m_pv1 = (grt2 != 0) && !redir[enc(grt2)];
      m_pw0 = enc(grt1);
      m_pw1 = enc(grt2);
      m_pp0 = m_pc[m_pw0];
      m_pp1 = m_pc[m_pw1];
      for (int w = 0; w < 8; w++) begin
         nxt[w] = m_pc[w];
         if (upd[w])                 nxt[w] = start_pc;
         else if (br[w])             nxt[w] = target;
         else if (grt1[w] || grt2[w]) nxt[w] = m_pc[w] + 32'd4;
      end
      for (int w = 0; w < 8; w++) m_pc[w] = nxt[w];
   endtask

   initial begin
      rst_n = 1'b0;
      grt1 = '0; grt2 = '0; upd = '0; br = '0; start_pc = '0; target = '0;
      inst0 = '0; inst1 = '0;
      for (int w = 0; w < 8; w++) m_pc[w] = '0;
      m_pv0 = 1'b0; m_pv1 = 1'b0; m_pw0 = 0; m_pw1 = 0; m_pp0 = '0; m_pp1 = '0;
      m_fetch = 0; m_squash = 0;
      #12;
      chk("rst_valid0", 32'(v0), 32'h0);
      chk("rst_valid1", 32'(v1), 32'h0);
      chk("rst_wid0", 32'(wid0), 32'h0);
      chk("rst_pc1", pco1, 32'h0);
      chk("rst_rd0", 32'(rd0), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // TM loads warps 0 and 2.
      drive(8'h00, 8'h00, 8'h05, 32'h100, 8'h00, 32'h0);
      tick();
      // Dual issue of warps 0 and 2.
      drive(8'h01, 8'h04, 8'h00, 32'h0, 8'h00, 32'h0);
      chk("lit_addr0_100", addr0, 32'h100);
      chk("lit_addr1_100", addr1, 32'h100);
      chk("lit_rd1", 32'(rd1), 32'h1);
      tick();
      drive(8'h01, 8'h00, 8'h00, 32'h0, 8'h00, 32'h0);
      chk("lit_valid0", 32'(v0), 32'h1);
      chk("lit_valid1", 32'(v1), 32'h1);
      chk("lit_wid1_2", 32'(wid1), 32'h2);
      chk("lit_pcout1", pco1, 32'h100);
      chk("lit_addr0_104", addr0, 32'h104);
      tick();
      // In-flight branch on warp 0.
      drive(8'h00, 8'h00, 8'h00, 32'h0, 8'h01, 32'h200);
      chk("lit_inflight_squash", 32'(v0), 32'h0);
      tick();
      // Same-cycle grant and branch on warp 2.
      drive(8'h01, 8'h04, 8'h00, 32'h0, 8'h04, 32'h300);
      chk("lit_addr0_200", addr0, 32'h200);
      chk("lit_addr1_104", addr1, 32'h104);
      chk("lit_rd1_sq", 32'(rd1), 32'h1);
      tick();
      drive(8'h00, 8'h04, 8'h00, 32'h0, 8'h00, 32'h0);
      chk("lit_valid0_ok", 32'(v0), 32'h1);
      chk("lit_samecyc_squash", 32'(v1), 32'h0);
      chk("lit_addr1_300", addr1, 32'h300);
      tick();
      // PC wrap on warp 3.
      drive(8'h00, 8'h00, 8'h08, 32'hFFFF_FFFC, 8'h00, 32'h0);
      tick();
      drive(8'h08, 8'h00, 8'h00, 32'h0, 8'h00, 32'h0);
      chk("lit_addr0_fffc", addr0, 32'hFFFF_FFFC);
      tick();
      drive(8'h08, 8'h00, 8'h00, 32'h0, 8'h00, 32'h0);
      chk("lit_wrap", addr0, 32'h0);
      tick();
      // TM load and branch together on warp 3, also squashing the in-flight fetch.
      drive(8'h00, 8'h00, 8'h08, 32'h40, 8'h08, 32'h80);
      chk("lit_tm_squash", 32'(v0), 32'h0);
      tick();
      drive(8'h08, 8'h00, 8'h00, 32'h0, 8'h00, 32'h0);
      chk("lit_tm_wins", addr0, 32'h40);
      tick();
      // Ten dual-grant cycles across all warps, one in-flight branch mid-stream.
      for (int i = 0; i < 10; i++) begin
         logic [7:0] a, b;
         a = 8'h01 << (i % 8);
         b = 8'h01 << ((i + 3) % 8);
         drive(a, b, 8'h00, 32'h0, 8'h00, 32'h0);
         tick();
      end
      drive(8'h00, 8'h00, 8'h00, 32'h0, 8'h10, 32'h500);
      tick();
      drive(8'h10, 8'h00, 8'h00, 32'h0, 8'h00, 32'h0);
      chk("lit_addr0_500", addr0, 32'h500);
      tick();
      drive(8'h00, 8'h00, 8'h00, 32'h0, 8'h00, 32'h0);
      tick();
      drive(8'h00, 8'h00, 8'h00, 32'h0, 8'h00, 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
